dmem_arbiter: RTL

- Shares the single DataMemory port between two masters.
- Master 0 is the pipeline MEM stage; master 1 is the secondary master (program/data loader or debug port).
- Grants one access per cycle, drives DataMemory's MemRead/MemWrite/address/writeData, and returns registered read data with a valid strobe.
- Supports locked multi-cycle ownership so one master can perform atomic read-modify-write sequences.

---
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single DataMemory port between master 0 (pipeline MEM
// stage) and master 1 (loader/debug). One access per cycle, combinational grant,
// registered read data with a one-cycle valid strobe, and locked ownership for
// atomic read-modify-write sequences.
// Optional build macro DMEM_ARB_RR_EN: round-robin tie-break in IDLE instead of
// fixed m0 priority.
module dmem_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_MemRead,
    output logic          mem_MemWrite,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_writeData,
    input  logic [DW-1:0] mem_readData,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} arbStateT;

    arbStateT      state;
    logic          pick0;
    logic          pick1;
    logic          anyPick;
    logic          winWe;
    logic [AW-1:0] winAddr;
    logic [DW-1:0] winWdata;
    logic [AW-1:0] addrHeld;
    logic [DW-1:0] wdataHeld;

`ifdef DMEM_ARB_RR_EN
    logic          lastOwner;   // 0 = m0 granted last, 1 = m1 granted last
`endif

    // Grant decision from current state and requests.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        unique case (state)
            StIdle: begin
                if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
                    pick0 = lastOwner;
                    pick1 = ~lastOwner;
`else
                    pick0 = 1'b1;
`endif
                end else begin
                    pick0 = m0_req;
                    pick1 = m1_req;
                end
            end
            StOwn0:  pick0 = m0_req;
            StOwn1:  pick1 = m1_req;
            default: ;
        endcase
    end

    // Winner's access fields; m1 only wins when m0 is not picked.
    always_comb begin
        anyPick  = pick0 | pick1;
        winWe    = pick0 ? m0_we    : m1_we;
        winAddr  = pick0 ? m0_addr  : m1_addr;
        winWdata = pick0 ? m0_wdata : m1_wdata;
    end

    // Memory-side outputs; grants forced low while reset is asserted so every output
    // shows its reset value even if a master keeps requesting.
    always_comb begin
        m0_gnt        = pick0 & rst_n;
        m1_gnt        = pick1 & rst_n;
        mem_MemRead   = anyPick & ~winWe & rst_n;
        mem_MemWrite  = anyPick & winWe & rst_n;
        mem_address   = (anyPick && rst_n) ? winAddr  : addrHeld;
        mem_writeData = (anyPick && rst_n) ? winWdata : wdataHeld;
    end

    // Ownership FSM with registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pick0 && m0_lock) begin
                        state <= StOwn0;
                        busy  <= 1'b1;
                    end else if (pick1 && m1_lock) begin
                        state <= StOwn1;
                        busy  <= 1'b1;
                    end
                end
                StOwn0: begin
                    // While owned and requesting, m0 is always granted, so only lock matters.
                    if (!m0_req || !m0_lock) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StOwn1: begin
                    if (!m1_req || !m1_lock) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Remember the last driven address/data so they hold when nobody is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrHeld  <= '0;
            wdataHeld <= '0;
        end else if (anyPick) begin
            addrHeld  <= winAddr;
            wdataHeld <= winWdata;
        end
    end

    // Capture read data on the grant edge; valid strobes for exactly the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= pick0 & ~m0_we;
            m1_rvalid <= pick1 & ~m1_we;
            if (pick0 && !m0_we) begin
                m0_rdata <= mem_readData;
            end
            if (pick1 && !m1_we) begin
                m1_rdata <= mem_readData;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Track the most recent grant for the round-robin tie-break; reset favours m0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastOwner <= 1'b1;
        end else if (pick0) begin
            lastOwner <= 1'b0;
        end else if (pick1) begin
            lastOwner <= 1'b1;
        end
    end
`endif

endmodule
